// File: rtl/conv_pe_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, default layer geometry and FSM encoding for
//               the convolution PE scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

   // Default layer geometry
   localparam int DEF_IFM_W    = 56;
   localparam int DEF_IFM_H    = 56;
   localparam int DEF_K        = 3;
   localparam int DEF_CH_WORDS = 2;
   localparam int DEF_NUM_PE   = 16;

   // Datapath widths
   localparam int ADDR_W = 20;
   localparam int CNT_W  = 8;

   // Scheduler states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACC      = 3'd1,
      ST_FLUSH    = 3'd2,
      ST_WAIT_OUT = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_pe_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_scheduler_if
// Description : Control, BRAM address and PE strobe bundle of the scheduler.
//               master = scheduler, slave = surrounding datapath/controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_pe_scheduler_if #(
   parameter int NUM_PE = conv_pkg::DEF_NUM_PE
) ();
   logic                      start;
   logic                      ofm_ready;
   logic [conv_pkg::ADDR_W-1:0] ifm_addr;
   logic [conv_pkg::ADDR_W-1:0] w_addr;
   logic [NUM_PE-1:0]         PE_en;
   logic [NUM_PE-1:0]         PE_finish;
   logic [7:0]                ofm_x;
   logic [7:0]                ofm_y;
   logic                      busy;
   logic                      done;

   modport master (
      input  start, ofm_ready,
      output ifm_addr, w_addr, PE_en, PE_finish, ofm_x, ofm_y, busy, done
   );

   modport slave (
      output start, ofm_ready,
      input  ifm_addr, w_addr, PE_en, PE_finish, ofm_x, ofm_y, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/conv_pe_scheduler_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_counter
// Description : Nested cw (fastest) / kx / ky counter walking one KxK window.
//               Exposes the next position so the caller can register addresses
//               in step with the count, plus a last-tap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_counter
   import conv_pkg::*;
#(
   parameter int K        = DEF_K,
   parameter int CH_WORDS = DEF_CH_WORDS
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             clear,
   input  wire logic             advance,
   output logic [CNT_W-1:0]      nxt_cw,
   output logic [CNT_W-1:0]      nxt_kx,
   output logic [CNT_W-1:0]      nxt_ky,
   output logic                  last_win
);

   logic [CNT_W-1:0] r_cw, r_kx, r_ky;
   logic             w_last_cw, w_last_kx, w_last_ky;

   // Wrap flags and successor position of the nested count
   always_comb begin
      w_last_cw = (r_cw == CNT_W'(CH_WORDS - 1));
      w_last_kx = (r_kx == CNT_W'(K - 1));
      w_last_ky = (r_ky == CNT_W'(K - 1));
      last_win  = w_last_cw && w_last_kx && w_last_ky;
      nxt_cw    = w_last_cw ? '0 : r_cw + 1'b1;
      nxt_kx    = r_kx;
      nxt_ky    = r_ky;
      if (w_last_cw) begin
         nxt_kx = w_last_kx ? '0 : r_kx + 1'b1;
         if (w_last_kx) begin
            nxt_ky = w_last_ky ? '0 : r_ky + 1'b1;
         end
      end
   end

   // Position register; wraps to 0 after the last tap so the next pixel starts clean
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cw <= '0;
         r_kx <= '0;
         r_ky <= '0;
      end else if (clear) begin
         r_cw <= '0;
         r_kx <= '0;
         r_ky <= '0;
      end else if (advance) begin
         r_cw <= nxt_cw;
         r_kx <= nxt_kx;
         r_ky <= nxt_ky;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_scheduler
// Description : Walks every output pixel of a stride-1, unpadded KxK conv,
//               issuing IFM/weight BRAM addresses, PE accumulate enables and
//               end-of-window strobes, with backpressure from the OFM sink.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pe_scheduler
   import conv_pkg::*;
#(
   parameter int IFM_W    = DEF_IFM_W,
   parameter int IFM_H    = DEF_IFM_H,
   parameter int K        = DEF_K,
   parameter int CH_WORDS = DEF_CH_WORDS,
   parameter int NUM_PE   = DEF_NUM_PE
) (
   input  wire logic              clk,
   input  wire logic              reset,
   conv_pe_scheduler_if.master    bus
);

   localparam logic [ADDR_W-1:0] C_IFM_W    = ADDR_W'(IFM_W);
   localparam logic [ADDR_W-1:0] C_K        = ADDR_W'(K);
   localparam logic [ADDR_W-1:0] C_CH_WORDS = ADDR_W'(CH_WORDS);

   state_t              r_state;
   logic [7:0]          r_ox, r_oy;
   logic [ADDR_W-1:0]   r_ifm, r_w;
   logic [NUM_PE-1:0]   r_pe_en, r_pe_fin;
   logic                r_busy, r_done;

   logic [CNT_W-1:0]    w_nxt_cw, w_nxt_kx, w_nxt_ky;
   logic                w_last_win;
   logic                w_clear, w_advance;
   logic                w_last_ox, w_last_oy, w_last_pixel;
   logic [7:0]          w_nxt_ox, w_nxt_oy;
   logic [ADDR_W-1:0]   w_ifm_next, w_w_next, w_pix_base;

   assign w_clear   = (r_state == ST_IDLE) && bus.start;
   assign w_advance = (r_state == ST_ACC);

   conv_window_counter #(
      .K        (K),
      .CH_WORDS (CH_WORDS)
   ) u_win (
      .clk      (clk),
      .reset    (reset),
      .clear    (w_clear),
      .advance  (w_advance),
      .nxt_cw   (w_nxt_cw),
      .nxt_kx   (w_nxt_kx),
      .nxt_ky   (w_nxt_ky),
      .last_win (w_last_win)
   );

   // Next tap addresses and next output-pixel origin
   always_comb begin
      w_last_ox    = (r_ox == 8'(IFM_W - K));
      w_last_oy    = (r_oy == 8'(IFM_H - K));
      w_last_pixel = w_last_ox && w_last_oy;
      w_nxt_ox     = w_last_ox ? 8'd0 : r_ox + 8'd1;
      w_nxt_oy     = r_oy;
      if (w_last_ox) begin
         w_nxt_oy = w_last_oy ? 8'd0 : r_oy + 8'd1;
      end
      w_ifm_next = ((ADDR_W'(r_oy) + ADDR_W'(w_nxt_ky)) * C_IFM_W
                    + ADDR_W'(r_ox) + ADDR_W'(w_nxt_kx)) * C_CH_WORDS
                   + ADDR_W'(w_nxt_cw);
      w_w_next   = (ADDR_W'(w_nxt_ky) * C_K + ADDR_W'(w_nxt_kx)) * C_CH_WORDS
                   + ADDR_W'(w_nxt_cw);
      w_pix_base = (ADDR_W'(w_nxt_oy) * C_IFM_W + ADDR_W'(w_nxt_ox)) * C_CH_WORDS;
   end

   // Scheduler FSM with registered outputs; addresses only move on ACC entry/inside ACC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_ox     <= '0;
         r_oy     <= '0;
         r_ifm    <= '0;
         r_w      <= '0;
         r_pe_en  <= '0;
         r_pe_fin <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_pe_en  <= '0;
         r_pe_fin <= '0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_ox    <= '0;
                  r_oy    <= '0;
                  r_ifm   <= '0;
                  r_w     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_ACC;
               end
            end
            ST_ACC: begin
               // BRAM data for this address arrives next cycle
               r_pe_en <= '1;
               if (w_last_win) begin
                  r_pe_fin <= '1;
                  r_state  <= ST_FLUSH;
               end else begin
                  r_ifm <= w_ifm_next;
                  r_w   <= w_w_next;
               end
            end
            ST_FLUSH, ST_WAIT_OUT: begin
               if (bus.ofm_ready) begin
                  if (w_last_pixel) begin
                     r_ox    <= '0;
                     r_oy    <= '0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_ox    <= w_nxt_ox;
                     r_oy    <= w_nxt_oy;
                     r_ifm   <= w_pix_base;
                     r_w     <= '0;
                     r_state <= ST_ACC;
                  end
               end else begin
                  r_state <= ST_WAIT_OUT;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ifm_addr  = r_ifm;
   assign bus.w_addr    = r_w;
   assign bus.PE_en     = r_pe_en;
   assign bus.PE_finish = r_pe_fin;
   assign bus.ofm_x     = r_ox;
   assign bus.ofm_y     = r_oy;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pe_scheduler
// Description : Randomized bench for conv_pe_scheduler. A loop-nest reference
//               walks pixels and taps and predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_pe_scheduler;

   localparam int IFM_W    = 5;
   localparam int IFM_H    = 4;
   localparam int K        = 3;
   localparam int CH_WORDS = 2;
   localparam int NUM_PE   = 8;
   localparam logic [31:0] ALL1 = 32'((64'd1 << NUM_PE) - 64'd1);

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   conv_pe_scheduler_if #(.NUM_PE(NUM_PE)) bus ();

   conv_pe_scheduler #(
      .IFM_W    (IFM_W),
      .IFM_H    (IFM_H),
      .K        (K),
      .CH_WORDS (CH_WORDS),
      .NUM_PE   (NUM_PE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run ever stalls
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ifm_ref(int ox, int oy, int kx, int ky, int cw);
      return ((oy + ky) * IFM_W + (ox + kx)) * CH_WORDS + cw;
   endfunction

   // wc = cycles already spent finishing this pixel (0 = FLUSH cycle)
   function automatic logic pick_ready(int mode, int pix, int wc);
      if (mode == 0) return 1'b1;
      if (mode == 2) return (pix != 0) || (wc >= 5);
      return (wc >= 6) || ($urandom_range(0, 2) == 0);
   endfunction

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_ifm"},  32'(bus.ifm_addr), 0);
      check_val({tag, "_w"},    32'(bus.w_addr), 0);
      check_val({tag, "_en"},   32'(bus.PE_en), 0);
      check_val({tag, "_fin"},  32'(bus.PE_finish), 0);
      check_val({tag, "_ox"},   32'(bus.ofm_x), 0);
      check_val({tag, "_oy"},   32'(bus.ofm_y), 0);
      check_val({tag, "_busy"}, 32'(bus.busy), 0);
      check_val({tag, "_done"}, 32'(bus.done), 0);
   endtask

   task automatic run_layer(input int mode);
      int   pix;
      int   idx;
      int   wc;
      int   last;
      logic rdy;
      check_val("idle_busy", 32'(bus.busy), 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      pix  = 0;
      last = 0;
      for (int oy = 0; oy <= IFM_H - K; oy++) begin
         for (int ox = 0; ox <= IFM_W - K; ox++) begin
            idx = 0;
            for (int ky = 0; ky < K; ky++) begin
               for (int kx = 0; kx < K; kx++) begin
                  for (int cw = 0; cw < CH_WORDS; cw++) begin
                     check_val("acc_ifm",  32'(bus.ifm_addr), 32'(ifm_ref(ox, oy, kx, ky, cw)));
                     check_val("acc_w",    32'(bus.w_addr), 32'(idx));
                     check_val("acc_en",   32'(bus.PE_en), (idx == 0) ? 32'd0 : ALL1);
                     check_val("acc_fin",  32'(bus.PE_finish), 0);
                     check_val("acc_busy", 32'(bus.busy), 1);
                     check_val("acc_done", 32'(bus.done), 0);
                     bus.start     = 1'($urandom_range(0, 1));
                     bus.ofm_ready = 1'($urandom_range(0, 1));
                     tick();
                     idx++;
                  end
               end
            end
            last = ifm_ref(ox, oy, K - 1, K - 1, CH_WORDS - 1);
            wc   = 0;
            do begin
               check_val("fin_en",   32'(bus.PE_en), (wc == 0) ? ALL1 : 32'd0);
               check_val("fin_fin",  32'(bus.PE_finish), (wc == 0) ? ALL1 : 32'd0);
               check_val("fin_ox",   32'(bus.ofm_x), 32'(ox));
               check_val("fin_oy",   32'(bus.ofm_y), 32'(oy));
               check_val("fin_ifm",  32'(bus.ifm_addr), 32'(last));
               check_val("fin_w",    32'(bus.w_addr), 32'(K * K * CH_WORDS - 1));
               check_val("fin_busy", 32'(bus.busy), 1);
               check_val("fin_done", 32'(bus.done), 0);
               rdy           = pick_ready(mode, pix, wc);
               bus.ofm_ready = rdy;
               bus.start     = 1'($urandom_range(0, 1));
               tick();
               wc++;
            end while (!rdy);
            pix++;
         end
      end
      check_val("done_pulse", 32'(bus.done), 1);
      check_val("done_busy",  32'(bus.busy), 1);
      check_val("done_fin",   32'(bus.PE_finish), 0);
      check_val("done_ifm",   32'(bus.ifm_addr), 32'(last));
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_val("post_done", 32'(bus.done), 0);
         check_val("post_busy", 32'(bus.busy), 0);
         check_val("post_en",   32'(bus.PE_en), 0);
         check_val("post_ifm",  32'(bus.ifm_addr), 32'(last));
         bus.ofm_ready = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   task automatic run_abort();
      bus.ofm_ready = 1'b1;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      // Now in the eighth ACC cycle: tap index 7
      check_val("abort_pre_ifm", 32'(bus.ifm_addr),
                32'(ifm_ref(0, 0, (7 / CH_WORDS) % K, 7 / (CH_WORDS * K), 7 % CH_WORDS)));
      check_val("abort_pre_busy", 32'(bus.busy), 1);
      #2 reset = 1'b0;
      #1;
      check_outputs_zero("abort");
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("abort_hold_fin",  32'(bus.PE_finish), 0);
         check_val("abort_hold_done", 32'(bus.done), 0);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_outputs_zero("abort_idle");
      end
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.ofm_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b1;
      tick();
      check_outputs_zero("idle");
      run_layer(0);
      run_layer(2);
      run_abort();
      run_layer(0);
      for (int i = 0; i < 3; i++) run_layer(1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_pe_scheduler.md
CONV_PE_SCHEDULER -- requirements
Module: conv_pe_scheduler

Interface
REQ-001 SHALL have parameter IFM_W, default 56, meaning IFM width in pixels.
REQ-002 SHALL have parameter IFM_H, default 56, meaning IFM height in pixels.
REQ-003 SHALL have parameter K, default 3, meaning square kernel size (stride 1, no padding).
REQ-004 SHALL have parameter CH_WORDS, default 2, meaning 64-bit words per pixel (8 int8 channels per word).
REQ-005 SHALL have parameter NUM_PE, default 16, meaning number of PEs/filters.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle pulse that begins a layer; ignored unless IDLE.
REQ-009 SHALL have port ofm_ready  input  1  downstream can accept a finished OFM pixel.
REQ-010 SHALL have port ifm_addr  output  20  IFM BRAM read address.
REQ-011 SHALL have port w_addr  output  20  weight BRAM read address, broadcast to all PEs.
REQ-012 SHALL have port PE_en  output  NUM_PE  per-PE accumulate enable.
REQ-013 SHALL have port PE_finish  output  NUM_PE  per-PE end-of-window pulse.
REQ-014 SHALL have port ofm_x, ofm_y  output  8 each  coordinates of pixel being finished.
REQ-015 SHALL have ports busy, done  output  1 each  layer in progress; one-cycle layer-complete pulse.

Function
REQ-016 SHALL implement FSM IDLE -> ACC -> FLUSH -> WAIT_OUT -> (ACC | DONE) -> IDLE.
REQ-017 SHALL in IDLE, on start, clear ox, oy, kx, ky, cw and enter ACC next cycle.
REQ-018 SHALL in ACC issue one address pair per cycle: ifm_addr = ((oy+ky)*IFM_W + (ox+kx))*CH_WORDS + cw; w_addr = (ky*K+kx)*CH_WORDS + cw.
REQ-019 SHALL iterate cw fastest, then kx, then ky; K*K*CH_WORDS cycles per output pixel (18 at default).
REQ-020 SHALL assert PE_en = all ones exactly one cycle after each ACC address (1-cycle BRAM read latency), zero otherwise.
REQ-021 SHALL enter FLUSH after last window address; in FLUSH assert final PE_en and PE_finish = all ones for that single cycle.
REQ-022 SHALL in WAIT_OUT hold ofm_x/ofm_y stable, PE_en/PE_finish zero, until ofm_ready = 1.
REQ-023 SHALL when ofm_ready = 1 in FLUSH cycle, skip WAIT_OUT wait (zero-stall path, no bubble beyond FLUSH).
REQ-024 SHALL advance ox (0..IFM_W-K), wrapping to 0 and incrementing oy (0..IFM_H-K); after last pixel go to DONE.
REQ-025 SHALL pulse done for one cycle in DONE, then return to IDLE; busy = 1 in every state except IDLE.
REQ-026 SHALL ignore start while busy; start coincident with DONE is ignored.
REQ-027 SHALL hold ifm_addr, w_addr at last value when not in ACC.

Reset
REQ-028 SHALL on reset = 0, asynchronously force IDLE; all counters, ifm_addr, w_addr, ofm_x, ofm_y to 0; PE_en, PE_finish, busy, done to 0.
REQ-029 SHALL abort any in-flight layer on reset mid-operation with no PE_finish emitted; next layer requires fresh start.

Structure
REQ-030 SHALL place FSM state encoding and default IFM_W/IFM_H/K/CH_WORDS/NUM_PE constants in shared package conv_pkg.
REQ-031 SHALL contain one sub-module conv_window_counter (nested cw/kx/ky counter with wrap and last flags); address arithmetic in top.

Verification
REQ-032 Params IFM_W=4, IFM_H=4, K=3, CH_WORDS=2, ofm_ready=1, start pulse -> 4 PE_finish pulses, each after 18 PE_en cycles; done 1 cycle after 4th pixel's FLUSH.
REQ-033 Same config, pixel (ox=1, oy=0) -> first ifm_addr = 2, last ifm_addr = ((2)*4+3)*2+1 = 23; w_addr sequence 0..17.
REQ-034 ofm_ready=0 for 5 cycles after first FLUSH -> WAIT_OUT 5 cycles, ofm_x=0/ofm_y=0 stable, PE_en=0, then resume with ox=1.
REQ-035 reset asserted at ACC cycle 7 -> all outputs 0 within same cycle, no PE_finish, no done; start afterward restarts at ifm_addr=0.
REQ-036 start pulsed while busy and in DONE cycle -> no restart; total PE_finish count stays 4.
REQ-037 Default 56x56, CH_WORDS=2 -> 2916 PE_finish pulses, max ifm_addr = 6271, done once.
